// File: rtl/led_pkg.sv
// Shared defaults for the LED fader: LED count and the PWM/decay tuning knobs.
package led_pkg;

   localparam int NUM_LEDS        = 8;
   localparam int PWM_BITS_DEF    = 8;
   localparam int DECAY_DIV_DEF   = 65536;
   localparam int DECAY_SHIFT_DEF = 3;

endpackage

// File: rtl/led_fade_cell.sv
// One LED channel: brightness register with exponential decay and a registered PWM compare.
module led_fade_cell
   import led_pkg::*;
#(
   parameter int PWM_BITS    = PWM_BITS_DEF,
   parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                led_in,
   input  logic                decay_tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led_out
);

   localparam logic [PWM_BITS-1:0] MAX_B  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] ZERO_B = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] ONE_B  = {{(PWM_BITS-1){1'b0}}, 1'b1};

   logic [PWM_BITS-1:0] b_r;
   logic [PWM_BITS-1:0] b_next_s;

   // Subtract a fraction of the brightness, never less than one step so the fade always ends.
   function automatic logic [PWM_BITS-1:0] decay_next(input logic [PWM_BITS-1:0] b);
      logic [PWM_BITS-1:0] step;
      step = b >> DECAY_SHIFT;
      step = (step == ZERO_B) ? ONE_B : step;
      return b - step;
   endfunction

   // Next brightness: a lit input wins over a simultaneous decay tick.
   always_comb begin
      b_next_s = b_r;
      if (led_in) begin
         b_next_s = MAX_B;
      end else if (decay_tick && (b_r != ZERO_B)) begin
         b_next_s = decay_next(b_r);
      end else begin
         b_next_s = b_r;
      end
   end

   // Brightness state and PWM output register; MAX forces a solid-on output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_r     <= ZERO_B;
         led_out <= 1'b0;
      end else begin
         b_r     <= b_next_s;
         led_out <= (b_r == MAX_B) || (b_r > pwm_cnt);
      end
   end

endmodule

// File: rtl/led_fader.sv
// PWM fader for the LED sweep: shared PWM counter and decay prescaler feeding eight fade cells.
module led_fader
   import led_pkg::*;
#(
   parameter int PWM_BITS    = PWM_BITS_DEF,
   parameter int DECAY_DIV   = DECAY_DIV_DEF,
   parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_LEDS-1:0] led_in,
   output logic [NUM_LEDS-1:0] led_out
);

   localparam int                   PRESC_W    = $clog2(DECAY_DIV);
   localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(DECAY_DIV - 1);
   localparam logic [PRESC_W-1:0]   PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
   localparam logic [PWM_BITS-1:0]  PWM_ONE    = {{(PWM_BITS-1){1'b0}}, 1'b1};

   logic [PWM_BITS-1:0] pwm_cnt_r;
   logic [PRESC_W-1:0]  presc_r;
   logic                decay_tick_s;

   assign decay_tick_s = (presc_r == PRESC_LAST);

   // Free-running PWM counter and decay prescaler, both wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_r <= {PWM_BITS{1'b0}};
         presc_r   <= {PRESC_W{1'b0}};
      end else begin
         pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
         presc_r   <= decay_tick_s ? {PRESC_W{1'b0}} : (presc_r + PRESC_ONE);
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_cell
      led_fade_cell #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_SHIFT(DECAY_SHIFT)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .led_in    (led_in[i]),
         .decay_tick(decay_tick_s),
         .pwm_cnt   (pwm_cnt_r),
         .led_out   (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: reference model plus directed and random stimulus.
module tb_led_fader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] led_a, led_b;
   logic [7:0] out_a, out_b;
   logic [7:0] ba [8];
   logic [7:0] bb2;

   int errors = 0;
   int checks = 0;
   int mb [8];
   int n;

   always #5 clk = ~clk;

   led_fader #(.PWM_BITS(8), .DECAY_DIV(4), .DECAY_SHIFT(2)) dut_a (
      .clk(clk), .rst(rst), .led_in(led_a), .led_out(out_a));

   // second instance: slow ticks and shift 1 so 255 -> 128 -> 64 holds long enough to measure duty
   led_fader #(.PWM_BITS(8), .DECAY_DIV(1024), .DECAY_SHIFT(1)) dut_b (
      .clk(clk), .rst(rst), .led_in(led_b), .led_out(out_b));

   for (genvar g = 0; g < 8; g++) begin : g_obs
      assign ba[g] = dut_a.g_cell[g].u_cell.b_r;
   end
   assign bb2 = dut_b.g_cell[2].u_cell.b_r;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock of dut_a: predict from spec rules, apply, then compare at the falling edge
   task automatic step_a(input logic [7:0] pat);
      logic [7:0] exp_out;
      bit         tick;
      int         d;
      led_a = pat;
      tick  = ((n % 4) == 3);
      for (int i = 0; i < 8; i++) exp_out[i] = (mb[i] == 255) || (mb[i] > (n % 256));
      for (int i = 0; i < 8; i++) begin
         if (pat[i]) mb[i] = 255;
         else if (tick && mb[i] > 0) begin
            d = mb[i] / 4;
            if (d < 1) d = 1;
            mb[i] = mb[i] - d;
         end
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      check("led_out", {24'd0, out_a}, {24'd0, exp_out});
      for (int i = 0; i < 8; i++) check("b", {24'd0, ba[i]}, mb[i]);
   endtask

   task automatic reset_model();
      n = 0;
      for (int i = 0; i < 8; i++) mb[i] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq [20] = '{192, 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
      int idx, guard, run, cnt, lit;
      bit tick;

      rst = 1'b1; led_a = 8'h00; led_b = 8'h00;
      reset_model();
      @(negedge clk); @(negedge clk);
      check("rst_out", {24'd0, out_a}, 32'd0);
      check("rst_pwm", {24'd0, dut_a.pwm_cnt_r}, 32'd0);
      check("rst_presc", {30'd0, dut_a.presc_r}, 32'd0);
      rst = 1'b0;

      // full on from the first edge after reset
      step_a(8'h01);
      check("first_pwm", {24'd0, dut_a.pwm_cnt_r}, 32'd1);
      check("first_presc", {30'd0, dut_a.presc_r}, 32'd1);
      check("full_on_lat", {24'd0, out_a}, 32'd0);
      for (int k = 0; k < 20; k++) begin
         step_a(8'h01);
         check("full_on", {24'd0, out_a}, 32'h01);
      end

      // decay sequence of b[0]
      idx = 0;
      for (int k = 0; k < 120; k++) begin
         tick = ((n % 4) == 3);
         step_a(8'h00);
         if (tick && idx < 20) begin
            check("decay_seq", {24'd0, ba[0]}, seq[idx]);
            idx++;
         end
      end
      check("decay_ticks", idx, 20);
      check("decay_floor", {24'd0, ba[0]}, 32'd0);

      // collision: relight b[5] mid-fade on a tick edge
      for (int k = 0; k < 3; k++) step_a(8'h20);
      guard = 0;
      while (!(mb[5] <= 61 && (n % 4) == 3) && guard < 100) begin
         step_a(8'h00);
         guard++;
      end
      check("collision_wait", guard < 100, 1);
      step_a(8'h20);
      check("collision", {24'd0, ba[5]}, 32'd255);

      // random sparse patterns
      for (int k = 0; k < 400; k++) begin
         logic [7:0] p;
         for (int i = 0; i < 8; i++) p[i] = ($urandom_range(0, 7) == 0);
         step_a(p);
      end

      // sweep: single bit walking every 8 cycles, handover aligned just before a tick
      for (int k = 0; k < 120; k++) step_a(8'h00);
      while ((n % 4) != 2) step_a(8'h00);
      run = 0;
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 8; c++) begin
            step_a(8'h01 << k);
            lit = 0;
            for (int i = 0; i < 8; i++) if (ba[i] == 8'd255) lit++;
            run = (lit >= 2) ? run + 1 : 0;
            check("handover", run <= 1, 1);
         end
      end
      for (int k = 0; k < 120; k++) step_a(8'h00);
      for (int i = 0; i < 8; i++) check("sweep_end", {24'd0, ba[i]}, 32'd0);

      // asynchronous reset mid-fade
      for (int k = 0; k < 3; k++) step_a(8'h08);
      while ((n % 4) != 0) step_a(8'h00);
      check("midfade_pre", mb[3] > 0 && mb[3] < 255, 1);
      #2 rst = 1'b1;
      #1;
      check("async_b3", {24'd0, ba[3]}, 32'd0);
      check("async_out", {24'd0, out_a}, 32'd0);
      check("async_pwm", {24'd0, dut_a.pwm_cnt_r}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      reset_model();
      step_a(8'h00);
      check("rerst_pwm", {24'd0, dut_a.pwm_cnt_r}, 32'd1);
      check("rerst_presc", {30'd0, dut_a.presc_r}, 32'd1);

      // duty check on dut_b
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int m = 0; m < 2612; m++) begin
         led_b = (m < 5) ? 8'h04 : 8'h00;
         @(posedge clk);
         @(negedge clk);
         if (m == 1022) check("tick_not_yet", {24'd0, bb2}, 32'd255);
         if (m == 1023) check("first_tick", {24'd0, bb2}, 32'd128);
         if (m == 2047) check("second_tick", {24'd0, bb2}, 32'd64);
         if (m >= 2100) cnt += out_b[2];
         if (m == 2355 || m == 2611) begin
            check("duty_64", cnt, 64);
            cnt = 0;
         end
      end
      check("duty_others", {24'd0, out_b & 8'hFB}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter PWM_BITS, default 8: width of the brightness registers and the PWM counter.
REQ-002 Parameter DECAY_DIV, default 65536: period of the decay tick, in clk cycles; legal range 2..2^24.
REQ-003 Parameter DECAY_SHIFT, default 3: decay step is brightness >> DECAY_SHIFT; legal range 1..PWM_BITS-1.
REQ-004 clk  input  1  Single clock; all state changes on its rising edge.
REQ-005 rst  input  1  Reset: asynchronous, active-high.
REQ-006 led_in  input  8  Target pattern from the LED sweep stage, synchronous to clk; bit high means that LED is lit.
REQ-007 led_out  output  8  PWM-dimmed drive to the physical LEDs, registered.

Function
REQ-008 The block SHALL hold one brightness register b[i] (PWM_BITS wide) per LED, i = 0..7.
REQ-009 A free-running PWM counter pwm_cnt (PWM_BITS wide) SHALL increment every cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-010 A prescaler SHALL count 0..DECAY_DIV-1 and wrap; decay_tick SHALL be high for exactly the one cycle in which the prescaler equals DECAY_DIV-1.
REQ-011 Each cycle, if led_in[i]=1, b[i] SHALL load MAX = 2^PWM_BITS-1.
REQ-012 If led_in[i]=0 and decay_tick=1 and b[i]>0, b[i] SHALL load b[i] - max(b[i]>>DECAY_SHIFT, 1).
REQ-013 If b[i]=0, b[i] SHALL hold at 0: no underflow, no wrap.
REQ-014 When led_in[i]=1 and decay_tick=1 in the same cycle, the load to MAX SHALL win.
REQ-015 If neither REQ-011 nor REQ-012 applies, b[i] SHALL hold its value.
REQ-016 led_out[i] SHALL be registered as (b[i]=MAX) OR (b[i] > pwm_cnt), using the b[i] and pwm_cnt values before the same clock edge.
REQ-017 Duty cycle is therefore b/2^PWM_BITS for b<MAX, 100% at MAX, and 0% at 0; a 0 brightness SHALL never produce a glitch pulse.
REQ-018 Latency SHALL be 2 cycles from a rising led_in[i] to led_out[i] going high (one cycle to load b, one cycle for the output register).
REQ-019 All eight LEDs SHALL be processed in parallel and independently; they share pwm_cnt and decay_tick.

Reset
REQ-020 While rst=1: every b[i]=0, pwm_cnt=0, prescaler=0, decay_tick=0, led_out=8'h00.
REQ-021 Reset assertion mid-fade SHALL clear all state immediately, without waiting for a clock edge.
REQ-022 On the first rising clk edge after rst deasserts, pwm_cnt SHALL become 1 and the prescaler SHALL become 1.
REQ-023 The first decay_tick after reset SHALL occur in cycle DECAY_DIV-1, counting the first post-reset edge as cycle 0.

Structure
REQ-024 The default values of PWM_BITS, DECAY_DIV and DECAY_SHIFT, and the LED count (8), SHALL live in the shared package led_pkg.
REQ-025 A sub-module led_fade_cell SHALL implement one b[i] register, its decay arithmetic and its output compare/register.
REQ-026 led_fade_cell SHALL be instantiated 8 times by a generate loop.
REQ-027 The top of led_fader SHALL contain only pwm_cnt, the prescaler and the generate loop.

Verification (bench parameters: PWM_BITS=8, DECAY_DIV=4, DECAY_SHIFT=2 unless stated)
REQ-028 Reset check: assert rst mid-fade with b[3]=100 -> b[3]=0 and led_out=8'h00 asynchronously; after release, pwm_cnt=1 at the first edge.
REQ-029 Full on: hold led_in=8'h01 -> led_out[0] high from edge 2 onward, continuously; led_out[7:1] stay 0.
REQ-030 Decay sequence: led_in 8'h01->8'h00 with b[0]=255 -> successive ticks give 192, 144, 108, 81, 61, 46, 35, 27, ...; the tail steps 3, 2, 1, 0; b[0] holds at 0.
REQ-031 Duty check: force b[2]=64 (DECAY_DIV=2^24 so no decay) -> exactly 64 high cycles in every 256-cycle PWM period of led_out[2].
REQ-032 Collision: raise led_in[5] in the same cycle as decay_tick with b[5]=40 -> b[5]=255, not 30.
REQ-033 Sweep integration: walk a single bit 0->7, one position every 8 cycles, with DECAY_DIV=4 -> each LED reloads to 255 while lit, then decays monotonically to 0, and no two LEDs are ever both at 255 except during a 1-cycle handover.
